// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings and
// the controller state enumeration.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

  // True for the two signed arithmetic operations (MULT, DIV).
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Core <-> multiply/divide unit bundle.
//   master (core):  drives start, op, flush, a, b
//   slave  (unit):  drives busy, done, div_by_zero, hi, lo
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             flush;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, flush, a, b,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, flush, a, b,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 datapath shared by multiply and divide.
//   load_i   : capture unsigned operands a_i/b_i and the mode is_div_i
//   step_i   : perform one shift-add (multiply) or restoring (divide) step
//   acc_o    : 2*WIDTH accumulator
//              multiply -> full product
//              divide   -> {remainder, quotient}
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand or divisor
  logic               div_q;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;   // WIDTH+1 bit partial remainder
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_d   = acc_q;
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: bring the next dividend bit into the remainder; subtract the
    // divisor if it fits. The result is below the divisor, so WIDTH bits hold it.
    div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opnd_q});
    div_rem = div_ge ? (div_sh[WIDTH-1:0] - opnd_q) : div_sh[WIDTH-1:0];
    if (step_i) begin
      if (div_q) acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};
      else       acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
    end else if (load_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      acc_q  <= {{WIDTH{1'b0}}, is_div_i ? a_i : b_i};
      opnd_q <= is_div_i ? b_i : a_i;
      div_q  <= is_div_i;
    end else begin
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : muldiv_if slave (start/op/flush/a/b in; busy/done/div_by_zero/hi/lo out)
// Sequence: IDLE -accept-> RUN (WIDTH steps) -> FIX (sign fix, HI/LO write, done).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     reset,
  muldiv_if.slave bus
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               load, step, fix;
  logic               idle_start, op_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  logic               is_div_q, neg_q_q, neg_r_q, zero_div_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, dz_q;

  assign idle_start = (state_q == IDLE) && bus.start;
  assign op_signed  = op_is_signed(bus.op);
  assign a_mag      = (op_signed && bus.a[MSB]) ? -bus.a : bus.a;
  assign b_mag      = (op_signed && bus.b[MSB]) ? -bus.b : bus.b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // op[2]=0 selects the four arithmetic ops; MTHI/MTLO and reserved stay here.
        if (bus.start && !bus.op[2]) begin
          load    = 1'b1;
          cnt_d   = CW'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        fix     = !bus.flush;  // flush beats the HI/LO write
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (reset),
    .load_i   (load),
    .step_i   (step),
    .is_div_i (bus.op[1]),
    .a_i      (a_mag),
    .b_i      (b_mag),
    .acc_o    (acc)
  );

  // Sign restoration. A zero divisor leaves the dividend magnitude as the
  // remainder, which the remainder sign turns back into the original a;
  // the quotient is forced to all ones regardless of signs.
  assign prod_fix = neg_q_q ? -acc : acc;
  always_comb begin
    hi_fix = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      hi_fix = neg_r_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (zero_div_q) lo_fix = '1;
      else            lo_fix = neg_q_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      zero_div_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      done_q <= fix;
      dz_q   <= fix && is_div_q && zero_div_q;
      if (fix) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end else if (idle_start && bus.op == OP_MTHI) begin
        hi_q <= bus.a;
      end else if (idle_start && bus.op == OP_MTLO) begin
        lo_q <= bus.a;
      end
      if (load) begin
        is_div_q   <= bus.op[1];
        neg_q_q    <= op_signed && (bus.a[MSB] ^ bus.b[MSB]);
        neg_r_q    <= op_signed && bus.a[MSB];
        zero_div_q <= (bus.b == '0);
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
